// File: rtl/vga_pkg.sv
// Shared constants and types for the menu text drawing path.
// Glyph cell geometry, default fetch latency and the cell-address type.
package vga_pkg;

    localparam int CHAR_W        = 8;
    localparam int CHAR_H        = 16;
    localparam int MENU_CHAR_LAT = 2;
    localparam int MENU_TEXT_LAT = MENU_CHAR_LAT + 3;

    typedef logic [7:0] char_xy_t;

    // Font rows store the leftmost pixel in bit 7.
    function automatic logic glyph_bit(input logic [7:0] row, input logic [2:0] px);
        return row[3'd7 - px];
    endfunction

endpackage

// File: rtl/font_rom.sv
// 8x16 glyph ROM, address {char_code, line}, one-cycle registered read.
module font_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  char_line_pixels
);

    logic [7:0] data_q;

    // Synchronous ROM read; rows not listed are blank.
    always_ff @(posedge clk) begin
        case (addr)
            11'h412: data_q <= 8'h10;
            11'h413: data_q <= 8'h38;
            11'h414: data_q <= 8'h6C;
            11'h415: data_q <= 8'hC6;
            11'h416: data_q <= 8'hC6;
            11'h417: data_q <= 8'hFE;
            11'h418: data_q <= 8'hC6;
            11'h419: data_q <= 8'hC6;
            11'h41A: data_q <= 8'hC6;
            11'h41B: data_q <= 8'hC6;
            11'h422: data_q <= 8'hFC;
            11'h423: data_q <= 8'h66;
            11'h424: data_q <= 8'h66;
            11'h425: data_q <= 8'h66;
            11'h426: data_q <= 8'h7C;
            11'h427: data_q <= 8'h66;
            11'h428: data_q <= 8'h66;
            11'h429: data_q <= 8'h66;
            11'h42A: data_q <= 8'h66;
            11'h42B: data_q <= 8'hFC;
            default: data_q <= 8'h00;
        endcase
    end

    assign char_line_pixels = data_q;

endmodule

// File: rtl/menu_delay.sv
// Generic shift-register delay line with synchronous active-high clear.
module menu_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift chain; every stage clears on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/menu_draw_text.sv
// Menu text overlay: issues cell addresses, reads glyph rows, draws them on the RGB stream.
// Optional MENU_TEXT_BG_EN makes the text window opaque with BG_COLOR.
module menu_draw_text
    import vga_pkg::*;
#(
    parameter int          XPOS       = 400,
    parameter int          YPOS       = 300,
    parameter int          COLS       = 16,
    parameter int          ROWS       = 8,
    parameter logic [11:0] TEXT_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter int          CHAR_LAT   = MENU_CHAR_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    input  logic [6:0]  char_code,
    input  logic [3:0]  char_line_ret,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int          LAT   = CHAR_LAT + 3;
    localparam int          DLY_W = 42;
    localparam logic [10:0] X0    = 11'(XPOS);
    localparam logic [10:0] Y0    = 11'(YPOS);
    localparam logic [11:0] X1    = 12'(XPOS + CHAR_W * COLS);
    localparam logic [11:0] Y1    = 12'(YPOS + CHAR_H * ROWS);
`ifdef MENU_TEXT_BG_EN
    localparam bit BG_EN = 1'b1;
`else
    localparam bit BG_EN = 1'b0;
`endif

    // Only the low bits of the wrapped offsets feed the cell address.
    logic [6:0]  rel_x_s;
    logic [7:0]  rel_y_s;
    logic        in_win_s;
    char_xy_t    char_xy_q;
    logic [3:0]  char_line_q;

    assign rel_x_s  = 7'(hcount_in - X0);
    assign rel_y_s  = 8'(vcount_in - Y0);
    assign in_win_s = (hcount_in >= X0) && ({1'b0, hcount_in} < X1) &&
                      (vcount_in >= Y0) && ({1'b0, vcount_in} < Y1);

    // Cell address and glyph line towards the text ROMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_xy_q   <= 8'h00;
            char_line_q <= 4'h0;
        end else begin
            char_xy_q   <= {rel_y_s[7:4], rel_x_s[6:3]};
            char_line_q <= rel_y_s[3:0];
        end
    end

    assign char_xy   = char_xy_q;
    assign char_line = char_line_q;

    logic [DLY_W-1:0] dly_in_s;
    logic [DLY_W-1:0] dly_out_s;
    logic [10:0]      dl_hcount_s;
    logic [10:0]      dl_vcount_s;
    logic             dl_hsync_s;
    logic             dl_hblnk_s;
    logic             dl_vsync_s;
    logic             dl_vblnk_s;
    logic [11:0]      dl_rgb_s;
    logic             dl_in_win_s;
    logic [2:0]       dl_px_s;

    assign dly_in_s = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in,
                       rgb_in, in_win_s, rel_x_s[2:0]};

    menu_delay #(
        .WIDTH (DLY_W),
        .DEPTH (LAT - 1)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dly_in_s),
        .dout (dly_out_s)
    );

    assign {dl_hcount_s, dl_hsync_s, dl_hblnk_s, dl_vcount_s, dl_vsync_s, dl_vblnk_s,
            dl_rgb_s, dl_in_win_s, dl_px_s} = dly_out_s;

    logic [7:0] font_row_s;

    font_rom u_font_rom (
        .clk              (clk),
        .addr             ({char_code, char_line_ret}),
        .char_line_pixels (font_row_s)
    );

    logic        glyph_s;
    logic [11:0] rgb_d;

    assign glyph_s = glyph_bit(font_row_s, dl_px_s);

    // Pixel select; in_win is not qualified by blanking, upstream owns that.
    always_comb begin
        rgb_d = dl_rgb_s;
        if (dl_in_win_s && glyph_s) begin
            rgb_d = TEXT_COLOR;
        end else if (dl_in_win_s && BG_EN) begin
            rgb_d = BG_COLOR;
        end else begin
            rgb_d = dl_rgb_s;
        end
    end

    logic [10:0] hcount_q;
    logic [10:0] vcount_q;
    logic        hsync_q;
    logic        hblnk_q;
    logic        vsync_q;
    logic        vblnk_q;
    logic [11:0] rgb_q;

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 11'd0;
            hsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vcount_q <= 11'd0;
            vsync_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= 12'h000;
        end else begin
            hcount_q <= dl_hcount_s;
            hsync_q  <= dl_hsync_s;
            hblnk_q  <= dl_hblnk_s;
            vcount_q <= dl_vcount_s;
            vsync_q  <= dl_vsync_s;
            vblnk_q  <= dl_vblnk_s;
            rgb_q    <= rgb_d;
        end
    end

    assign hcount_out = hcount_q;
    assign hsync_out  = hsync_q;
    assign hblnk_out  = hblnk_q;
    assign vcount_out = vcount_q;
    assign vsync_out  = vsync_q;
    assign vblnk_out  = vblnk_q;
    assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_menu_draw_text.sv
// Scoreboard bench for menu_draw_text; a stub returns the char stream CHAR_LAT cycles late.
// Build with MENU_TEXT_BG_EN to check the opaque-window variant.
module tb_menu_draw_text;

    localparam int          LAT     = 5;
    localparam logic [11:0] TEXT_C  = 12'hFFF;
    localparam logic [11:0] BG_C    = 12'h000;
`ifdef MENU_TEXT_BG_EN
    localparam bit BG_EN_TB = 1'b1;
`else
    localparam bit BG_EN_TB = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] h;
        logic        hs;
        logic        hb;
        logic [10:0] v;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in;
    logic        hsync_in;
    logic        hblnk_in;
    logic [10:0] vcount_in;
    logic        vsync_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;
    logic [7:0]  char_xy;
    logic [3:0]  char_line;
    logic [6:0]  char_code;
    logic [3:0]  char_line_ret;
    logic [10:0] hcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic [10:0] vcount_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    logic [6:0]  stub_code;
    logic [3:0]  stub_line_q [2];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    menu_draw_text dut (
        .clk           (clk),
        .rst           (rst),
        .hcount_in     (hcount_in),
        .hsync_in      (hsync_in),
        .hblnk_in      (hblnk_in),
        .vcount_in     (vcount_in),
        .vsync_in      (vsync_in),
        .vblnk_in      (vblnk_in),
        .rgb_in        (rgb_in),
        .char_xy       (char_xy),
        .char_line     (char_line),
        .char_code     (char_code),
        .char_line_ret (char_line_ret),
        .hcount_out    (hcount_out),
        .hsync_out     (hsync_out),
        .hblnk_out     (hblnk_out),
        .vcount_out    (vcount_out),
        .vsync_out     (vsync_out),
        .vblnk_out     (vblnk_out),
        .rgb_out       (rgb_out)
    );

    // Text ROM stub: two-cycle return path, same code in every cell.
    always @(posedge clk) begin
        stub_line_q[0] <= char_line;
        stub_line_q[1] <= stub_line_q[0];
    end

    assign char_line_ret = stub_line_q[1];
    assign char_code     = stub_code;

    function automatic logic [7:0] gold_a(input logic [3:0] line);
        case (line)
            4'd2:    return 8'h10;
            4'd3:    return 8'h38;
            4'd4:    return 8'h6C;
            4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: return 8'hC6;
            4'd7:    return 8'hFE;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [11:0] model_rgb(input logic [10:0] h, input logic [10:0] v,
                                              input logic [11:0] rgb, input logic [6:0] code);
        logic        win;
        logic [10:0] rx;
        logic [10:0] ry;
        logic [7:0]  row;
        logic        bitv;
        win  = (h >= 11'd400) && (h < 11'd528) && (v >= 11'd300) && (v < 11'd428);
        rx   = h - 11'd400;
        ry   = v - 11'd300;
        row  = (code == 7'h41) ? gold_a(ry[3:0]) : 8'h00;
        bitv = row[3'd7 - rx[2:0]];
        if (win && bitv)          return TEXT_C;
        else if (win && BG_EN_TB) return BG_C;
        else                      return rgb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hs,
                        input logic hb, input logic vs, input logic vb, input logic [11:0] rgb);
        exp_t e;
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hs;
        hblnk_in  = hb;
        vsync_in  = vs;
        vblnk_in  = vb;
        rgb_in    = rgb;
        e.h = h; e.hs = hs; e.hb = hb; e.v = v; e.vs = vs; e.vb = vb;
        e.rgb = model_rgb(h, v, rgb, stub_code);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            check($sformatf("timing h=%0d v=%0d", e.h, e.v),
                  64'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}),
                  64'({e.h, e.hs, e.hb, e.v, e.vs, e.vb}));
            check($sformatf("rgb h=%0d v=%0d", e.h, e.v), 64'(rgb_out), 64'(e.rgb));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
    endtask

    task automatic do_reset;
        exp_t z;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst char_xy",   64'(char_xy),    64'd0);
        check("rst char_line", 64'(char_line),  64'd0);
        check("rst hcount",    64'(hcount_out), 64'd0);
        check("rst vcount",    64'(vcount_out), 64'd0);
        check("rst syncs",     64'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 64'd0);
        check("rst rgb",       64'(rgb_out),    64'd0);
        rst = 1'b0;
        z = '0;
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(z);
    endtask

    initial begin
        rst       = 1'b1;
        stub_code = 7'h41;
        hcount_in = 11'd0; vcount_in = 11'd0;
        hsync_in  = 1'b0;  hblnk_in  = 1'b0;
        vsync_in  = 1'b0;  vblnk_in  = 1'b0;
        rgb_in    = 12'h000;
        @(posedge clk);
        do_reset();

        // hsync pulse at hcount 100 must reappear five cycles later.
        for (int h = 95; h <= 106; h++)
            step(11'(h), 11'd10, (h == 100), 1'b0, 1'b0, 1'b0, 12'h123);

        step(11'd400, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
        check("char_xy 400,300",   64'(char_xy),   64'h00);
        check("char_line 400,300", 64'(char_line), 64'h0);
        step(11'd415, 11'd317, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
        check("char_xy 415,317",   64'(char_xy),   64'h11);
        check("char_line 415,317", 64'(char_line), 64'h1);

        // Glyph 'A' over lines of the first cell row, crossing both side edges.
        for (int v = 300; v < 316; v++)
            for (int h = 396; h <= 410; h++)
                step(11'(h), 11'(v), 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
        for (int v = 426; v <= 429; v++)
            for (int h = 518; h <= 531; h++)
                step(11'(h), 11'(v), 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
        for (int h = 398; h <= 402; h++)
            step(11'(h), 11'd299, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);

        // Just outside the window with a blank char: pass-through.
        idle(LAT + 2);
        stub_code = 7'h7F;
        for (int v = 300; v < 428; v += 9) begin
            step(11'd399, 11'(v), 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
            step(11'd528, 11'(v), 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
        end
        idle(LAT + 2);
        stub_code = 7'h41;

        // Reset in the middle of a drawn line, then resume the same line.
        for (int h = 396; h <= 404; h++)
            step(11'(h), 11'd305, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
        do_reset();
        for (int h = 405; h <= 420; h++)
            step(11'(h), 11'd305, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);

        // Random walk around the window with random timing bits.
        for (int i = 0; i < 400; i++)
            step(11'($urandom_range(390, 540)), 11'($urandom_range(295, 435)),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
        idle(LAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
